// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg -- shared encodings for the rr_mux output stage and its arbiter.
// Holds the arbitration mode encodings and the output FSM state type.
package rr_mux_pkg;

    // Arbitration mode encodings (value of the mode input)
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational one-hot grant selection.
// Round-robin mode searches upward from ptr with wrap N-1 -> 0;
// fixed mode picks the lowest requesting index.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    // One spare bit so ptr + offset cannot overflow before the wrap.
    logic [SELW:0]   w_sum;
    logic [SELW-1:0] w_idx;
    logic            w_found;

    // Scan candidates in priority order; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        w_found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (mode == MODE_FIXED) begin
                w_sum = (SELW+1)'(k);
            end else begin
                w_sum = {1'b0, ptr} + (SELW+1)'(k);
            end
            if (w_sum >= (SELW+1)'(N)) begin
                w_sum = w_sum - (SELW+1)'(N);
            end
            w_idx = w_sum[SELW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// rr_mux -- N-channel valid/ready multiplexer with a single output register.
// Arbitration is round-robin (mode=1) or fixed lowest-index priority (mode=0).
// Optional feature macro: RR_MUX_SEL_OUT_EN adds out_sel, the granted index
// registered alongside out_data.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
`ifdef RR_MUX_SEL_OUT_EN
    output logic [SELW-1:0]      out_sel,
`endif
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t            r_state;
    state_t            w_state_next;
    logic [SELW-1:0]   r_rr_ptr;
    logic [WIDTH-1:0]  r_data;
    logic [N-1:0]      w_grant;
    logic [SELW-1:0]   w_grant_idx;
    logic [SELW-1:0]   w_ptr_next;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_can_load;
    logic              w_load;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_rr_ptr),
        .mode      (mode),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // The output register can take a word when empty or draining this cycle;
    // reset blocks every input handshake.
    assign w_can_load = (r_state == ST_EMPTY) || out_ready;
    assign w_load     = w_can_load && (|in_valid) && !rst;
    assign in_ready   = w_grant & {N{w_can_load && !rst}};

    // Pointer moves just past the winner so that channel yields next time.
    assign w_ptr_next = (w_grant_idx == SELW'(N-1)) ? '0 : w_grant_idx + SELW'(1);

    // Pick the granted channel's data (grant is one-hot).
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output FSM next state: fill on load, drain on accept without refill.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_next = ST_FULL;
            ST_FULL:  if (out_ready && !w_load) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the granted word on load; hold it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= w_sel_data;
        end
    end

    // Round-robin pointer advances only on round-robin loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_load && (mode == MODE_RR)) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

`ifdef RR_MUX_SEL_OUT_EN
    logic [SELW-1:0] r_sel;

    // Granted index travels with the data word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
        end else if (w_load) begin
            r_sel <= w_grant_idx;
        end
    end

    assign out_sel = r_sel;
`endif

    assign out_data  = r_data;
    assign out_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux -- directed-vector bench for rr_mux (WIDTH=8, N=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_rr_mux;

    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic               clk;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
`ifdef RR_MUX_SEL_OUT_EN
    logic [1:0]         out_sel;
`endif

    int n_vec = 0;
    int n_err = 0;

    rr_mux #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
`ifdef RR_MUX_SEL_OUT_EN
        .out_sel   (out_sel),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch_data(input int ch, input logic [7:0] d);
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    // Round-robin expectations: words and the in_ready pattern after each load.
    logic [7:0] exp_rr_data [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    logic [3:0] exp_rr_rdy  [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch_data(i, 8'hA0 + 8'(i));

        // Reset held across edges with all channels requesting
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_out_data",  32'(out_data),  32'h00);

        // Round-robin sweep
        rst = 1'b0;
        #1;
        chk("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr_data[%0d]", i),  32'(out_data),  32'(exp_rr_data[i]));
            chk($sformatf("rr_valid[%0d]", i), 32'(out_valid), 32'h1);
            chk($sformatf("rr_ready[%0d]", i), 32'(in_ready),  32'(exp_rr_rdy[i]));
        end
        // pointer now 1

        // Fixed priority, channels 1 and 3 requesting
        mode     = 1'b0;
        in_valid = 4'b1010;
        #1;
        chk("fix_ready", 32'(in_ready), 32'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fix_data[%0d]", i), 32'(out_data), 32'hA1);
            chk($sformatf("fix_rdy[%0d]", i),  32'(in_ready), 32'b0010);
        end
        // Fixed priority ignores pointer (=1): all valid gives ch0
        in_valid = 4'b1111;
        #1;
        chk("fix_all_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("fix_all_data", 32'(out_data), 32'hA0);

        // Backpressure: load 8'h55 then stall for 5 cycles
        set_ch_data(2, 8'h55);
        in_valid = 4'b0100;
        tick();
        chk("bp_load", 32'(out_data), 32'h55);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_ready[%0d]", i), 32'(in_ready), 32'h0);
            tick();
            chk($sformatf("bp_data[%0d]", i),  32'(out_data),  32'h55);
            chk($sformatf("bp_valid[%0d]", i), 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("bp_release_data", 32'(out_data), 32'hA0);
        set_ch_data(2, 8'hA2);

        // Wrap/skip: pointer still 1; grant ch2 moves it to 3
        mode     = 1'b1;
        in_valid = 4'b0100;
        tick();
        chk("wrap_setup", 32'(out_data), 32'hA2);
        in_valid = 4'b0001;
        #1;
        chk("wrap_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("wrap_data", 32'(out_data), 32'hA0);
        // pointer now 1: all valid must grant ch1
        in_valid = 4'b1111;
        #1;
        chk("wrap_ptr1_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("wrap_ptr1_data", 32'(out_data), 32'hA1);
        // pointer now 2

        // No requests: output drains, nothing loads
        in_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_ready", 32'(in_ready),  32'h0);
        tick();
        chk("idle_valid", 32'(out_valid), 32'h0);

        // Mid-transfer reset: grant ch2 (pointer -> 3), stall, then reset
        in_valid = 4'b0100;
        tick();
        chk("mr_full", 32'(out_data), 32'hA2);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_valid", 32'(out_valid), 32'h0);
        chk("mr_async_data",  32'(out_data),  32'h00);
        chk("mr_async_ready", 32'(in_ready),  32'h0);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1001;
        #1;
        chk("mr_ptr0_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("mr_ptr0_data", 32'(out_data), 32'hA0);
`ifdef RR_MUX_SEL_OUT_EN
        chk("mr_sel", 32'(out_sel), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
